// File: rtl/dsram_bridge_if.sv
// Data SRAM bus between the memory-stage bridge (master) and the SRAM/bus fabric (slave).
// Uses a req/addr_ok/data_ok handshake with variable latency.
interface dsram_bridge_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dsram_bridge.sv
// M-stage load/store bridge onto a variable-latency data SRAM bus: builds strobes and
// replicated store data, aligns/extends load data, and stalls the pipeline while busy.
module dsram_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_sign,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_done,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_addr_err,
  output logic                  cpu_bus_err,
  dsram_bridge_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam bit          WD_EN    = (TIMEOUT != 0);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;

  logic        wr_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        bus_err_q;

  logic        misaligned;
  logic        accept;
  logic        capture;
  logic        timeout;
  logic        expired;
  logic        req_c;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Alignment, strobes and replicated store data are derived from the live CPU request
  // so they can be latched in the same cycle the request is accepted.
  always_comb begin
    misaligned = 1'b0;
    wstrb_new  = 4'b1111;
    wdata_new  = cpu_wdata;
    case (cpu_size)
      2'd0: begin
        wstrb_new = 4'b0001 << cpu_addr[1:0];
        wdata_new = {4{cpu_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = cpu_addr[0];
        wstrb_new  = 4'b0011 << {cpu_addr[1], 1'b0};
        wdata_new  = {2{cpu_wdata[15:0]}};
      end
      default: begin
        misaligned = |cpu_addr[1:0];
      end
    endcase
    if (!cpu_wr) begin
      wstrb_new = 4'b0000;
    end
  end

  always_comb begin
    load_byte = bus.rdata[7:0];
    case (addr_q[1:0])
      2'd0: load_byte = bus.rdata[7:0];
      2'd1: load_byte = bus.rdata[15:8];
      2'd2: load_byte = bus.rdata[23:16];
      2'd3: load_byte = bus.rdata[31:24];
      default: load_byte = bus.rdata[7:0];
    endcase
    load_half = addr_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    case (size_q)
      2'd0:    load_data = {{24{sign_q & load_byte[7]}}, load_byte};
      2'd1:    load_data = {{16{sign_q & load_half[15]}}, load_half};
      default: load_data = bus.rdata;
    endcase
  end

  // The watchdog budget spans ADDR and DATA together; a handshake on the expiry cycle wins.
  assign expired = WD_EN && (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    cpu_stall    = 1'b0;
    cpu_done     = 1'b0;
    cpu_addr_err = 1'b0;
    req_c        = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (misaligned) begin
            cpu_addr_err = 1'b1;
          end else begin
            accept    = 1'b1;
            cpu_stall = 1'b1;
            state_nxt = ADDR;
          end
        end
      end
      ADDR: begin
        cpu_stall = 1'b1;
        req_c     = 1'b1;
        if (bus.addr_ok) begin
          state_nxt = DATA;
        end else if (expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DATA: begin
        cpu_stall = 1'b1;
        if (bus.data_ok) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        cpu_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      sign_q    <= 1'b0;
      addr_q    <= 32'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
      cpu_rdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      bus_err_q <= timeout;
      if (accept) begin
        cnt     <= 16'd0;
        wr_q    <= cpu_wr;
        size_q  <= cpu_size;
        sign_q  <= cpu_sign;
        addr_q  <= cpu_addr;
        wstrb_q <= wstrb_new;
        wdata_q <= wdata_new;
      end else if (state == ADDR || state == DATA) begin
        cnt <= cnt + 16'd1;
      end
      // Stores complete without disturbing the last load result.
      if (capture && !wr_q) begin
        cpu_rdata <= load_data;
      end
    end
  end

  assign cpu_bus_err = bus_err_q;
  assign bus.req     = req_c;
  assign bus.wr      = wr_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;

endmodule

// File: tb/tb_dsram_bridge.sv
// Self-checking bench for dsram_bridge: a timeline model drives expectations for every
// cycle of the main instance; a second instance with TIMEOUT=4 exercises the watchdog.
module tb_dsram_bridge;

  logic        clk;
  logic        resetn;

  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic        cpu_sign;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_addr_err;
  logic        cpu_bus_err;

  logic        w_req;
  logic        w_wr;
  logic [1:0]  w_size;
  logic        w_sign;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_stall;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_addr_err;
  logic        w_bus_err;

  dsram_bridge_if bif ();
  dsram_bridge_if wif ();

  dsram_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_req      (cpu_req),
    .cpu_wr       (cpu_wr),
    .cpu_size     (cpu_size),
    .cpu_sign     (cpu_sign),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_done     (cpu_done),
    .cpu_rdata    (cpu_rdata),
    .cpu_addr_err (cpu_addr_err),
    .cpu_bus_err  (cpu_bus_err),
    .bus          (bif)
  );

  dsram_bridge #(.TIMEOUT(4)) dut_wd (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_req      (w_req),
    .cpu_wr       (w_wr),
    .cpu_size     (w_size),
    .cpu_sign     (w_sign),
    .cpu_addr     (w_addr),
    .cpu_wdata    (w_wdata),
    .cpu_stall    (w_stall),
    .cpu_done     (w_done),
    .cpu_rdata    (w_rdata),
    .cpu_addr_err (w_addr_err),
    .cpu_bus_err  (w_bus_err),
    .bus          (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        exp_valid;
  logic        e_stall, e_done, e_req, e_aerr, e_berr;
  logic [31:0] exp_rdata;
  logic        exp_bwr;
  logic [31:0] exp_baddr, exp_bwdata;
  logic [3:0]  exp_bwstrb;

  int          stall_cnt, req_cnt;
  logic [3:0]  seen_wstrb;
  logic [31:0] seen_wdata;
  logic        seen_wr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Model: strobes/data/load results from plain arithmetic on the access description.
  function automatic logic [3:0] model_strb(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (!wr) return 4'b0000;
    if (size == 2'd0) return 4'(1 << a);
    if (size == 2'd1) return 4'(3 << (a - (a % 2)));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
    if (size == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] raw);
    logic [31:0] w;
    logic [31:0] v;
    w = raw >> (8 * (addr % 4));
    if (size == 2'd0) begin
      v = w & 32'hFF;
      if (sign && v >= 32'd128) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'd1) begin
      v = w & 32'hFFFF;
      if (sign && v >= 32'd32768) v = v | 32'hFFFF_0000;
      return v;
    end
    return raw;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checkOutput("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      checkOutput("cpu_done", 32'(cpu_done), 32'(e_done));
      checkOutput("cpu_addr_err", 32'(cpu_addr_err), 32'(e_aerr));
      checkOutput("cpu_bus_err", 32'(cpu_bus_err), 32'(e_berr));
      checkOutput("bus_req", 32'(bif.req), 32'(e_req));
      checkOutput("cpu_rdata", cpu_rdata, exp_rdata);
      if (e_req) begin
        checkOutput("bus_addr", bif.addr, exp_baddr);
        checkOutput("bus_wr", 32'(bif.wr), 32'(exp_bwr));
        checkOutput("bus_wstrb", 32'(bif.wstrb), 32'(exp_bwstrb));
        checkOutput("bus_wdata", bif.wdata, exp_bwdata);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic s, input logic d, input logic r, input logic a, input logic b);
    e_stall = s;
    e_done  = d;
    e_req   = r;
    e_aerr  = a;
    e_berr  = b;
  endtask

  task automatic sample();
    @(negedge clk);
    stall_cnt += int'(cpu_stall);
    req_cnt   += int'(bif.req);
    if (bif.req) begin
      seen_wstrb = bif.wstrb;
      seen_wdata = bif.wdata;
      seen_wr    = bif.wr;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      cpu_req      = 1'b0;
      bif.addr_ok  = 1'b0;
      bif.data_ok  = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
    end
  endtask

  // One access: accept, a_dly+1 ADDR cycles, d_dly+1 DATA cycles, DONE (returns in DONE).
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] raw, input int a_dly, input int d_dly);
    stall_cnt = 0;
    req_cnt   = 0;
    next_cycle();
    cpu_req     = 1'b1;
    cpu_wr      = wr;
    cpu_size    = size;
    cpu_sign    = sign;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    bif.addr_ok = 1'b0;
    bif.data_ok = 1'b0;
    exp_bwr     = wr;
    exp_baddr   = addr;
    exp_bwstrb  = model_strb(wr, size, addr);
    exp_bwdata  = model_wdata(size, wdata);
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_valid   = 1'b1;
    sample();
    for (int i = 0; i <= a_dly; i++) begin
      next_cycle();
      bif.addr_ok = (i == a_dly);
      bif.data_ok = (i != a_dly) && (i % 2 == 0);
      bif.rdata   = ~raw;
      set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      sample();
    end
    for (int i = 0; i <= d_dly; i++) begin
      next_cycle();
      bif.addr_ok = (i != d_dly) && (i % 2 == 1);
      bif.data_ok = (i == d_dly);
      bif.rdata   = (i == d_dly) ? raw : ~raw;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
    end
    next_cycle();
    bif.addr_ok = 1'b0;
    bif.data_ok = 1'b0;
    bif.rdata   = 32'h0;
    if (!wr) exp_rdata = model_load(size, sign, addr, raw);
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
  endtask

  task automatic misaligned(input logic [1:0] size, input logic [31:0] addr);
    stall_cnt = 0;
    req_cnt   = 0;
    next_cycle();
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_size = size;
    cpu_addr = addr;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    next_cycle();
    cpu_req = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
  endtask

  initial begin
    resetn      = 1'b0;
    exp_valid   = 1'b0;
    exp_rdata   = 32'h0;
    cpu_req     = 1'b0;
    cpu_wr      = 1'b0;
    cpu_size    = 2'd0;
    cpu_sign    = 1'b0;
    cpu_addr    = 32'h0;
    cpu_wdata   = 32'h0;
    bif.addr_ok = 1'b0;
    bif.data_ok = 1'b0;
    bif.rdata   = 32'h0;
    w_req       = 1'b0;
    w_wr        = 1'b0;
    w_size      = 2'd0;
    w_sign      = 1'b0;
    w_addr      = 32'h0;
    w_wdata     = 32'h0;
    wif.addr_ok = 1'b0;
    wif.data_ok = 1'b0;
    wif.rdata   = 32'h0;
    exp_bwr     = 1'b0;
    exp_baddr   = 32'h0;
    exp_bwdata  = 32'h0;
    exp_bwstrb  = 4'h0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    exp_valid = 1'b1;
    sample();
    checkOutput("reset bus_addr", bif.addr, 32'h0);
    checkOutput("reset bus_wdata", bif.wdata, 32'h0);
    checkOutput("reset bus_wstrb", 32'(bif.wstrb), 32'h0);
    checkOutput("reset bus_wr", 32'(bif.wr), 32'h0);
    checkOutput("reset wd stall", 32'(w_stall), 32'h0);
    next_cycle();
    resetn = 1'b1;
    sample();
    idle(1);

    $display("[TB] load word, minimum latency");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    checkOutput("t1 rdata", cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("t1 stall cycles", 32'(stall_cnt), 32'd3);

    $display("[TB] store byte, back to back");
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h203, 32'h1234_5678, 32'h0, 0, 0);
    checkOutput("t2 wstrb", 32'(seen_wstrb), 32'h8);
    checkOutput("t2 wdata", seen_wdata, 32'h7878_7878);
    checkOutput("t2 wr", 32'(seen_wr), 32'h1);
    checkOutput("t2 rdata held", cpu_rdata, 32'hDEAD_BEEF);
    idle(1);

    $display("[TB] load half signed/unsigned");
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h8001_FFFF, 0, 0);
    checkOutput("t3 signed", cpu_rdata, 32'hFFFF_8001);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h8001_FFFF, 0, 0);
    checkOutput("t3 unsigned", cpu_rdata, 32'h0000_8001);
    idle(1);

    applyStimulus(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 32'h80AA_BBCC, 0, 1);
    checkOutput("byte signed lane3", cpu_rdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 32'h1122_F344, 1, 0);
    checkOutput("byte unsigned lane1", cpu_rdata, 32'h0000_00F3);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h102, 32'hAAAA_5A5A, 32'h0, 0, 0);
    checkOutput("half store wstrb", 32'(seen_wstrb), 32'hC);
    checkOutput("half store wdata", seen_wdata, 32'h5A5A_5A5A);
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h10, 32'h0123_4567, 32'h0, 0, 0);
    checkOutput("size3 store wstrb", 32'(seen_wstrb), 32'hF);
    idle(1);

    $display("[TB] misaligned accesses");
    misaligned(2'd2, 32'h101);
    checkOutput("t4 bus_req cycles", 32'(req_cnt), 32'd0);
    checkOutput("t4 stall cycles", 32'(stall_cnt), 32'd0);
    misaligned(2'd1, 32'h203);
    misaligned(2'd2, 32'h102);
    checkOutput("misaligned req cycles", 32'(req_cnt), 32'd0);
    idle(1);

    $display("[TB] long latency with stray handshakes");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0BAD_F00D, 5, 7);
    checkOutput("t5 bus_req cycles", 32'(req_cnt), 32'd6);
    checkOutput("t5 stall cycles", 32'(stall_cnt), 32'd15);
    checkOutput("t5 rdata", cpu_rdata, 32'h0BAD_F00D);
    idle(2);

    $display("[TB] watchdog expiry");
    next_cycle();
    w_req  = 1'b1;
    w_wr   = 1'b0;
    w_size = 2'd2;
    w_addr = 32'h40;
    sample();
    checkOutput("wd accept stall", 32'(w_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      checkOutput("wd addr bus_req", 32'(wif.req), 32'd1);
      checkOutput("wd addr bus_err", 32'(w_bus_err), 32'd0);
    end
    next_cycle();
    w_req = 1'b0;
    sample();
    checkOutput("wd expiry bus_err", 32'(w_bus_err), 32'd1);
    checkOutput("wd expiry bus_req", 32'(wif.req), 32'd0);
    checkOutput("wd expiry stall", 32'(w_stall), 32'd0);
    checkOutput("wd expiry done", 32'(w_done), 32'd0);
    next_cycle();
    sample();
    checkOutput("wd bus_err pulse", 32'(w_bus_err), 32'd0);

    $display("[TB] watchdog handshake on expiry cycle");
    next_cycle();
    w_req  = 1'b1;
    w_addr = 32'h44;
    sample();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      wif.addr_ok = (i == 3);
      sample();
    end
    next_cycle();
    wif.addr_ok = 1'b0;
    wif.data_ok = 1'b1;
    wif.rdata   = 32'hCAFE_F00D;
    sample();
    checkOutput("wd data stall", 32'(w_stall), 32'd1);
    checkOutput("wd data bus_err", 32'(w_bus_err), 32'd0);
    checkOutput("wd data bus_req", 32'(wif.req), 32'd0);
    next_cycle();
    wif.data_ok = 1'b0;
    sample();
    checkOutput("wd done", 32'(w_done), 32'd1);
    checkOutput("wd done bus_err", 32'(w_bus_err), 32'd0);
    checkOutput("wd done rdata", w_rdata, 32'hCAFE_F00D);
    next_cycle();
    w_req = 1'b0;
    sample();
    checkOutput("wd after done bus_err", 32'(w_bus_err), 32'd0);
    checkOutput("wd after done stall", 32'(w_stall), 32'd0);

    $display("[TB] reset during DATA");
    next_cycle();
    cpu_req   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_size  = 2'd2;
    cpu_addr  = 32'h300;
    exp_bwr   = 1'b0;
    exp_baddr = 32'h300;
    exp_bwstrb = 4'h0;
    exp_bwdata = cpu_wdata;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    next_cycle();
    bif.addr_ok = 1'b1;
    set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    next_cycle();
    bif.addr_ok = 1'b0;
    resetn      = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    next_cycle();
    resetn      = 1'b1;
    cpu_req     = 1'b0;
    bif.data_ok = 1'b1;
    bif.rdata   = 32'h5555_AAAA;
    exp_rdata   = 32'h0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    checkOutput("post reset rdata", cpu_rdata, 32'h0);
    idle(2);
    checkOutput("post reset done", 32'(cpu_done), 32'd0);

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
